// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and helpers for the unified-memory port arbiter.
// Both requesters see identical handshakes; only the owner differs.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_t;

   localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

   typedef struct packed {
      owner_t      owner;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
   } mem_req_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & WORD_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_starve.sv
// Saturating starvation counter and the data-first priority decision.
// Fetch wins when data is idle or after STARVE_MAX data grants in a row.
module arb_starve_ctr #(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic d_req,
   input  logic if_elig,
   input  logic grant,
   output logic fetch_wins
);

   logic [3:0] cnt;
   logic       cnt_at_max;

   assign cnt_at_max = (cnt == 4'(STARVE_MAX));
   assign fetch_wins = if_elig & (~d_req | cnt_at_max);

   // NOTE: sequential state is written only with non-blocking assignments.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (grant) begin
         if (!if_elig || fetch_wins)
            cnt <= '0;
         else if (!cnt_at_max)
            cnt <= cnt + 4'd1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, fixed-latency memory between instruction
// fetch and load/store, one access at a time: IDLE -> ISSUE -> WAIT -> RESP.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wmask,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   input  logic        halt_in,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   state_t     state;
   logic [2:0] wait_cnt;
   owner_t     owner;
   logic       owner_we;
   logic       if_elig;
   logic       grant;
   logic       fetch_wins;
   mem_req_t   win;

   assign if_elig = if_req & ~halt_in;
   assign grant   = (state == IDLE) & (d_req | if_elig);
   assign busy    = (state != IDLE);

   arb_starve_ctr #(
      .STARVE_MAX(STARVE_MAX)
   ) u_starve (
      .clk       (clk),
      .rst       (rst),
      .d_req     (d_req),
      .if_elig   (if_elig),
      .grant     (grant),
      .fetch_wins(fetch_wins)
   );

   // NOTE: every field gets a default first so this block cannot infer a latch.
   always_comb begin
      win = '0;
      if (fetch_wins) begin
         win.owner = OWN_IF;
         win.addr  = word_align(if_addr);
      end else begin
         win.owner = OWN_D;
         win.we    = d_we;
         win.addr  = word_align(d_addr);
         win.wdata = d_we ? d_wdata : '0;
         win.wmask = d_we ? d_wmask : 4'b0000;
      end
   end

   // mem_* registers double as the latched request; they read 0 outside ISSUE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         owner     <= OWN_IF;
         owner_we  <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wmask <= '0;
         if_ack    <= 1'b0;
         d_ack     <= 1'b0;
         if_rdata  <= '0;
         d_rdata   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant) begin
                  state     <= ISSUE;
                  owner     <= win.owner;
                  owner_we  <= win.we;
                  mem_en    <= 1'b1;
                  mem_we    <= win.we;
                  mem_addr  <= win.addr;
                  mem_wdata <= win.wdata;
                  mem_wmask <= win.wmask;
               end
            end
            ISSUE: begin
               state     <= WAIT;
               wait_cnt  <= 3'(MEM_LAT - 1);
               mem_en    <= 1'b0;
               mem_we    <= 1'b0;
               mem_addr  <= '0;
               mem_wdata <= '0;
               mem_wmask <= '0;
            end
            WAIT: begin
               if (wait_cnt == 3'd0) begin
                  state <= RESP;
                  if (owner == OWN_IF) begin
                     if_ack   <= 1'b1;
                     if_rdata <= mem_rdata;
                  end else begin
                     d_ack   <= 1'b1;
                     d_rdata <= owner_we ? '0 : mem_rdata;
                  end
               end else begin
                  wait_cnt <= wait_cnt - 3'd1;
               end
            end
            RESP: begin
               state  <= IDLE;
               if_ack <= 1'b0;
               d_ack  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the CPU instruction-fetch requester and the load/store (data) requester. Intended for the multi-cycle and pipelined successors of the single-cycle CPU, where IMEM and DMEM are merged into one array.
- Sequences each access through a fixed-latency memory with a req/ack handshake.
- Applies data-first priority with a starvation guard for fetch.
- Stops granting fetches once the CPU halts.

Parameters:
- MEM_LAT, 1: cycles from the mem_en cycle to the cycle where mem_rdata is valid; legal range 1..7.
- STARVE_MAX, 4: consecutive data grants, while fetch is pending, before fetch is forced to win; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- if_req  in  1  fetch request; held high, with if_addr stable, until if_ack.
- if_addr  in  32  fetch byte address; bits [1:0] are ignored.
- if_ack  out  1  one-cycle pulse; if_rdata is valid in the same cycle.
- if_rdata  out  32  fetched word.
- d_req  in  1  data request; held high, with all d_* fields stable, until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address; bits [1:0] are ignored.
- d_wdata  in  32  store data.
- d_wmask  in  4  byte enables for a store.
- d_ack  out  1  one-cycle completion pulse.
- d_rdata  out  32  load word; valid with d_ack; 0 on stores.
- halt_in  in  1  CPU halt; level, sticky until reset.
- mem_en  out  1  one-cycle memory strobe.
- mem_we  out  1  write enable; qualified by mem_en.
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- mem_wdata  out  32  write data.
- mem_wmask  out  4  byte enables; 4'b0000 on reads.
- mem_rdata  in  32  read data, valid MEM_LAT cycles after the mem_en cycle.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, immediate):
  - state = IDLE.
  - All outputs = 0.
  - Starvation counter = 0.
  - Latched request fields = 0.
  - Reset mid-access aborts the access: no ack is issued, and the requester must re-request.
- States and transitions:
  - IDLE -> ISSUE, when a winner exists at the clock edge.
  - ISSUE (mem_en=1, exactly 1 cycle) -> WAIT.
  - WAIT counts MEM_LAT cycles, using a 3-bit down-counter loaded with MEM_LAT-1. In the last WAIT cycle, mem_rdata is sampled into the response register.
  - -> RESP (the ack of the owner is 1 for exactly 1 cycle) -> IDLE.
- Winner selection (in IDLE only):
  - Eligible fetch = if_req & ~halt_in.
  - Data wins by default.
  - Fetch wins if data is not requesting, or if the starvation counter == STARVE_MAX.
- Starvation counter:
  - Increments on each data grant made while fetch is eligible, saturating at STARVE_MAX.
  - Clears on a fetch grant, or when an arbitration finds fetch not eligible.
- Owner and latching:
  - The owner (IF or D) and its address/we/wdata/wmask are latched at the grant edge.
  - mem_* outputs are driven from the latched values during ISSUE; they are 0 in all other states.
  - Fetch accesses always read (mem_we=0, mem_wmask=0).
- Latency:
  - A request first high in cycle 0 (arbiter IDLE) gets mem_en in cycle 1 and its ack in cycle 2+MEM_LAT.
  - Back-to-back throughput is one access per MEM_LAT+3 cycles.
  - A request still high during RESP is not re-granted in that cycle; the requester drops req the cycle after ack.
- Store completion: ack is issued with the same timing as a load; d_rdata = 0.
- Response data: if_rdata and d_rdata hold their last value outside ack cycles. Only the owner's rdata is updated.
- halt_in:
  - Asserting it never aborts an in-flight fetch; that fetch completes normally.
  - While it is high, fetch is never granted. Data requests are still served so that stores can drain.
- Simultaneous events: d_req and if_req rising in the same IDLE cycle -> data wins unless the starvation counter == STARVE_MAX.
- Requests arriving while busy are not sampled until IDLE.

Decomposition:
- Shared package/header holds:
  - State encodings: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3.
  - Owner encoding: OWN_IF=1'b0, OWN_D=1'b1.
  - Word-align mask constant.
- One natural sub-module, arb_starve_ctr: the saturating starvation counter plus the priority decision, with inputs d_req, if_elig, and grant; output fetch_wins.
- The remainder stays flat.

Test Plan:
- Fetch-only access: MEM_LAT=1, memory word 0x00400093 at 0x0; if_req=1, if_addr=0x0 in cycle 0 -> mem_en in cycle 1 with mem_addr=0x0 and mem_we=0; if_ack in cycle 3 with if_rdata=0x00400093.
- Aligned store: d_req, d_we=1, d_addr=0x102, d_wdata=0xDEADBEEF, d_wmask=4'b1100 -> mem_addr=0x100 and mem_wmask=4'b1100 during the mem_en cycle; d_ack after 2+MEM_LAT cycles with d_rdata=0.
- Conflict and starvation: STARVE_MAX=4, d_req and if_req both held high continuously (each re-requests right after its ack) -> grant order D,D,D,D,IF,D,D,D,D,IF; no if_ack gap longer than 5 accesses.
- Halt during fetch: halt_in rises in the WAIT cycle of a fetch -> that if_ack is still issued; a further if_req is never acked, while a d_req issued afterwards is acked normally.
- Async reset mid-access: rst pulse during WAIT -> all outputs drop to 0 immediately, with no ack; after rst falls, a re-issued if_req completes in 2+MEM_LAT cycles.
- Latency sweep: MEM_LAT=3 -> ack in cycle 5 after request; back-to-back requests complete every 6 cycles.
